// File: rtl/word_splitter.sv
// Word-to-byte serializer: emits NBYTES bytes of a word, least-significant byte first.
// Optional odd-parity output out_par is built when WORD_SPLITTER_PARITY_EN is defined.
module word_splitter #(
    parameter int NBYTES = 4,
    parameter int BYTE_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NBYTES*BYTE_W-1:0] in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [BYTE_W-1:0]        out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
`ifdef WORD_SPLITTER_PARITY_EN
    output logic                     out_par,
`endif
    output logic                     busy
);

    localparam int WORD_W = NBYTES * BYTE_W;
    localparam int CNT_W  = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BYTE_W-1:0]   out_q, out_d;
    logic                out_valid_q, out_valid_d;
    logic [WORD_W-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                load;
    logic                xfer;
    logic                last_byte;

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        shift_d     = shift_q;
        count_d     = count_q;

        last_byte = out_valid_q && (count_q == LAST_CNT);
        xfer      = out_valid_q && out_ready;
        // out_ready feeds in_ready combinationally so a new word loads on the last-byte handshake.
        in_ready  = (state_q == IDLE) || (last_byte && out_ready);
        load      = in_valid && in_ready;

        if (load) begin
            out_d       = in[BYTE_W-1:0];
            shift_d     = in >> BYTE_W;
            count_d     = '0;
            out_valid_d = 1'b1;
            state_d     = SEND;
        end else if (state_q == SEND && xfer) begin
            if (!last_byte) begin
                out_d   = shift_q[BYTE_W-1:0];
                shift_d = shift_q >> BYTE_W;
                count_d = count_q + CNT_W'(1);
            end else begin
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            shift_q     <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
        end
    end

`ifdef WORD_SPLITTER_PARITY_EN
    logic out_par_q, out_par_d;

    // Derived from out_d so parity always tracks the registered byte, including holds.
    always_comb begin
        out_par_d = ~^out_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_par_q <= 1'b1;
        end else begin
            out_par_q <= out_par_d;
        end
    end

    assign out_par = out_par_q;
`endif

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign out_last  = last_byte;
    assign busy      = (state_q == SEND);

endmodule

// File: tb/tb_word_splitter.sv
// Self-checking bench for word_splitter: directed scenarios plus randomized traffic
// checked against a byte-queue reference model.
module tb_word_splitter;

    localparam int NBYTES = 4;
    localparam int BYTE_W = 8;

    logic        clk;
    logic        rst;
    logic [31:0] in_word;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;
`ifdef WORD_SPLITTER_PARITY_EN
    logic        out_par;
`endif

    word_splitter #(.NBYTES(NBYTES), .BYTE_W(BYTE_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_word),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef WORD_SPLITTER_PARITY_EN
        .out_par   (out_par),
`endif
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         vectors;
    int         miscompares;
    logic [7:0] exp_q[$];
    logic       accepted;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: apply inputs, check against the model mid-cycle, advance.
    task automatic tick(input logic r, input logic iv, input logic [31:0] w, input logic ordy);
        logic exp_ready;
        rst       = r;
        in_valid  = iv;
        in_word   = w;
        out_ready = ordy;
        accepted  = 1'b0;
        @(negedge clk);
        if (r) begin
            exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && ordy);
            check("out_valid", out_valid, exp_q.size() != 0);
            check("busy", busy, exp_q.size() != 0);
            check("in_ready", in_ready, exp_ready);
            if (exp_q.size() != 0) begin
`ifdef WORD_SPLITTER_PARITY_EN
                check("out_par", out_par, ~^exp_q[0]);
`endif
                if (ordy) begin
                    check("out", out, exp_q[0]);
                    check("out_last", out_last, exp_q.size() == 1);
                    $display("byte %02h last=%0d", out, out_last);
                    void'(exp_q.pop_front());
                end else begin
                    check("out_hold", out, exp_q[0]);
                end
            end
            if (iv && exp_ready) begin
                for (int b = 0; b < NBYTES; b++) exp_q.push_back(w[b*8 +: 8]);
                accepted = 1'b1;
                $display("word %08h accepted", w);
            end
        end
        @(posedge clk);
        #1;
        if (!r) begin
            exp_q.delete();
            check("rst_out", out, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_in_ready", in_ready, 1);
            check("rst_busy", busy, 0);
`ifdef WORD_SPLITTER_PARITY_EN
            check("rst_out_par", out_par, 1);
`endif
        end
    endtask

    task automatic push_word(input logic [31:0] w, input logic ordy);
        int n;
        n = 0;
        do begin
            tick(1'b1, 1'b1, w, ordy);
            n++;
        end while (!accepted && n < 20);
        check("accept_timeout", accepted, 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick(1'b1, 1'b0, 32'h0, 1'b1);
            n++;
        end
        check("drain_timeout", exp_q.size(), 0);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        logic [6:0]  pattern;
        logic        pend;
        logic [31:0] pw;
        logic        r;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_word     = '0;
        out_ready   = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) tick(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);

        // Basic word with out_ready held high
        push_word(32'hA1B2C3D4, 1'b1);
        drain();

        // Stalls: out_ready sequence 1,0,0,1,0,1,1
        pattern = 7'b1101001;
        push_word(32'hA1B2C3D4, 1'b1);
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 32'h0, pattern[i]);
        drain();

        // Back-to-back words
        push_word(32'h03020100, 1'b1);
        push_word(32'h07060504, 1'b1);
        drain();

        // Reset after two bytes, then a fresh word
        push_word(32'hDEADBEEF, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 32'h55555555, 1'b1);
        push_word(32'h11223344, 1'b1);
        drain();

        // New word offered mid-word must wait for the last-byte handshake
        push_word(32'hCAFEF00D, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b0);
        push_word(32'h12345678, 1'b1);
        drain();

        // Parity word
        push_word(32'h0000FF01, 1'b1);
        drain();

        // Randomized traffic with occasional reset
        pend = 1'b0;
        pw   = '0;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) != 0);
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1'b1;
                pw   = $urandom;
            end
            tick(r, pend, pw, $urandom_range(0, 3) != 0);
            if (accepted || !r) pend = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
